// File: rtl/align_shift_if.sv
// rtl/align_shift_if.sv - handshake and data bundle for the align_shift mantissa alignment stage
//
// Purpose: groups the upstream (swap stage) and downstream (mantissa adder)
// valid/ready handshakes and their payloads into one port.
// Signals:
//   in_valid, in_ready         upstream handshake
//   op1_swap, op2_swap [22:0]  fractions of larger / smaller exponent operand
//   op1_hidden, op2_hidden     hidden bits
//   shift [7:0]                exponent difference (unsigned)
//   swap                       swap flag from the swap stage
//   out_valid, out_ready       downstream handshake
//   big_mant [23:0]            {op1_hidden, op1_swap}
//   small_mant [26:0]          aligned {mant[23:0], G, R, S}
//   swap_out                   registered swap flag
// Modports: slave = alignment stage, master = its environment.
interface align_shift_if;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] op1_swap;
    logic [22:0] op2_swap;
    logic        op1_hidden;
    logic        op2_hidden;
    logic [7:0]  shift;
    logic        swap;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] big_mant;
    logic [26:0] small_mant;
    logic        swap_out;

    modport slave (
        input  in_valid, op1_swap, op2_swap, op1_hidden, op2_hidden, shift, swap,
        input  out_ready,
        output in_ready, out_valid, big_mant, small_mant, swap_out
    );

    modport master (
        output in_valid, op1_swap, op2_swap, op1_hidden, op2_hidden, shift, swap,
        output out_ready,
        input  in_ready, out_valid, big_mant, small_mant, swap_out
    );
endinterface

// File: rtl/align_shift.sv
// rtl/align_shift.sv - iterative right-shift alignment of the smaller mantissa with guard/round/sticky
//
// Purpose: restores hidden bits, then shifts the smaller-exponent mantissa
// right by min(shift, 27), STEP bits per cycle, folding every bit that falls
// off the bottom into the sticky bit (small_mant[0]).
// Parameters: STEP - bits shifted per SHIFT cycle (1, 2, 4 or 8).
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    align_shift_if.slave (handshakes, operands, results)
// Optional feature: define ALIGN_EARLY_OUT_EN to finish in one cycle when the
// result is trivially known (shift >= 27 or zero mantissa).
module align_shift #(
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         reset,
    align_shift_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [26:0] work_q,  work_d;
    logic [4:0]  rem_q,   rem_d;
    logic [23:0] big_q,   big_d;
    logic        swap_q,  swap_d;

    logic [26:0] shifted;
    logic [4:0]  step_k;
    logic [4:0]  rem_clamp;
    logic [23:0] op2_mant;

    assign op2_mant  = {bus.op2_hidden, bus.op2_swap};
    // Beyond 27 places every mantissa bit is already in sticky.
    assign rem_clamp = (bus.shift > 8'd27) ? 5'd27 : bus.shift[4:0];
    assign step_k    = (rem_q < 5'(STEP)) ? rem_q : 5'(STEP);

    // One-bit shifts repeated up to STEP times; the incoming bit 1 is ORed
    // into bit 0 so sticky accumulates and is never cleared.
    always_comb begin
        shifted = work_q;
        for (int i = 0; i < STEP; i++) begin
            if (5'(i) < rem_q) begin
                shifted = {1'b0, shifted[26:2], shifted[1] | shifted[0]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        big_d   = big_q;
        swap_d  = swap_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    big_d  = {bus.op1_hidden, bus.op1_swap};
                    swap_d = bus.swap;
`ifdef ALIGN_EARLY_OUT_EN
                    if (rem_clamp == 5'd27 || op2_mant == 24'd0) begin
                        work_d  = {26'd0, |op2_mant};
                        rem_d   = 5'd0;
                        state_d = DONE;
                    end else begin
                        work_d  = {op2_mant, 3'b000};
                        rem_d   = rem_clamp;
                        state_d = (rem_clamp != 5'd0) ? SHIFT : DONE;
                    end
`else
                    work_d  = {op2_mant, 3'b000};
                    rem_d   = rem_clamp;
                    state_d = (rem_clamp != 5'd0) ? SHIFT : DONE;
`endif
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step_k;
                if (rem_d == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= 27'd0;
            rem_q   <= 5'd0;
            big_q   <= 24'd0;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            big_q   <= big_d;
            swap_q  <= swap_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE) && !reset;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.big_mant   = big_q;
    assign bus.small_mant = work_q;
    assign bus.swap_out   = swap_q;

endmodule
